fetch_queue: RTL

Instruction buffer between the instruction fetch stage and the decode stage of the ARM pipeline. It holds up to DEPTH fetched {pc, instruction} pairs, so fetch can keep running while decode is stalled. It uses valid/ready handshakes on both sides. A branch-taken flush from execute discards every buffered entry.

---
 rtl/fetch_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry {pc, instr} FIFO with valid/ready on both sides and branch flush.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a zero-latency pass-through when the queue is empty.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        stored_vld;
    logic        full;
    logic        push;
    logic        pop;
    logic [63:0] head;

    assign stored_vld = (count_q != '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign head       = mem_q[rd_ptr_q];

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready = ~full;
    assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_act;

    // Empty queue forwards the fetch entry straight to decode in the same cycle.
    assign bypass_act = ~stored_vld & in_valid & ~flush;
    assign out_valid  = (stored_vld & ~flush) | bypass_act;
    assign out_pc     = bypass_act ? in_pc    : head[63:32];
    assign out_instr  = bypass_act ? in_instr : head[31:0];
    assign push       = in_valid & in_ready & ~flush & ~(bypass_act & out_ready);
    assign pop        = stored_vld & out_ready & ~flush;
`else
    assign out_valid  = stored_vld & ~flush;
    assign out_pc     = head[63:32];
    assign out_instr  = head[31:0];
    assign push       = in_valid & in_ready & ~flush;
    assign pop        = out_valid & out_ready;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Flush wins over push/pop; storage is left as-is.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
        end
    end

endmodule
